// File: rtl/alu_md.sv
// Combinational ALU plus a multi-cycle multiply/divide unit with HI/LO result registers.
// The ALU path is independent of the multiply/divide state and of reset.
module alu_md #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] C,
  output logic             Over,
  input  logic [2:0]       MdOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SHW     = $clog2(WIDTH);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {IDLE, RUN} state_t;

  // ---------------- combinational ALU ----------------
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum, diff, sra;

  assign sh   = A[SHW-1:0];
  assign sum  = A + B;
  assign diff = A - B;
  assign sra  = $signed(B) >>> sh;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    C    = '0;
    Over = 1'b0;
    case (Op)
      4'b0000: C = A & B;
      4'b0001: C = A | B;
      4'b0010: begin
        C    = sum;
        Over = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0011: C = A ^ B;
      4'b0110: begin
        C    = diff;
        Over = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0111: C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1000: C = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1001: C = sra;
      4'b1010: C = B;
      4'b1100: C = ~(A | B);
      4'b1101: C = B << sh;
      4'b1110: C = B >> sh;
      default: C = '0;
    endcase
  end

  // ---------------- multiply / divide unit ----------------
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b;
  md_op_t           md_op;
  md_op_t           md_in;
  logic             launch, done, wr_hi, wr_lo, is_mul_in;

  assign md_in     = md_op_t'(MdOp);
  assign is_mul_in = (md_in == MD_MULT) || (md_in == MD_MULTU);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    done      = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: if (Start) begin
        case (md_in)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            launch    = 1'b1;
            state_nxt = RUN;
          end
          MD_MTHI: wr_hi = 1'b1;
          MD_MTLO: wr_lo = 1'b1;
          default: ;
        endcase
      end
      RUN: if (cnt == CW'(1)) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == RUN);

  // Full-width products: sign-extending before an unsigned multiply gives the signed product mod 2^(2W).
  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic [WIDTH-1:0]   quo, rem;

  assign prod_s = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
  assign prod_u = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  always_comb begin
    quo = '1;
    rem = op_a;
    if (op_b != '0) begin
      if (md_op == MD_DIV) begin
        if (op_a == MIN_NEG && op_b == '1) begin
          quo = MIN_NEG;
          rem = '0;
        end else begin
          quo = $signed(op_a) / $signed(op_b);
          rem = $signed(op_a) % $signed(op_b);
        end
      end else begin
        quo = op_a / op_b;
        rem = op_a % op_b;
      end
    end
  end

  always_comb begin
    case (md_op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      default:  res = {rem, quo};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      if (launch)             cnt <= is_mul_in ? CW'(MUL_LAT) : CW'(DIV_LAT);
      else if (state == RUN)  cnt <= cnt - CW'(1);
      if (done) begin
        HI <= res[2*WIDTH-1:WIDTH];
        LO <= res[WIDTH-1:0];
      end else begin
        if (wr_hi) HI <= A;
        if (wr_lo) LO <= A;
      end
    end
  end

  // NOTE: operand latches carry no reset; they are only read in RUN, which always follows a load.
  always_ff @(posedge clk) begin
    if (launch) begin
      op_a  <= A;
      op_b  <= B;
      md_op <= md_in;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: expected ALU and HI/LO results are queued at drive time
// and popped when the DUT produces them; a second 16-bit instance covers parameterisation.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, C, HI, LO;
  logic [3:0]  Op;
  logic [2:0]  MdOp;
  logic        Start, Over, Busy;

  logic [15:0] a16, b16, c16, hi16, lo16;
  logic [3:0]  op16;
  logic [2:0]  md16;
  logic        st16, over16, busy16;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } md_exp_t;

  md_exp_t     md_sb[$];
  logic [32:0] alu_sb[$];
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  alu_md dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .C(C), .Over(Over),
    .MdOp(MdOp), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  alu_md #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(10)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .Op(op16), .C(c16), .Over(over16),
    .MdOp(md16), .Start(st16), .Busy(busy16), .HI(hi16), .LO(lo16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: {Over, C}; overflow judged in 64-bit signed arithmetic, shifts bit by bit.
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [31:0] c;
    logic        ov;
    longint      s;
    int          sh;
    c  = '0;
    ov = 1'b0;
    sh = int'(a[4:0]);
    case (op)
      4'h0: c = a & b;
      4'h1: c = a | b;
      4'h2, 4'h6: begin
        s  = (op == 4'h2) ? longint'($signed(a)) + longint'($signed(b))
                          : longint'($signed(a)) - longint'($signed(b));
        c  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: c = a ^ b;
      4'h7: c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: c = (a < b) ? 32'd1 : 32'd0;
      4'h9: begin c = b; for (int i = 0; i < sh; i++) c = {c[31], c[31:1]}; end
      4'hA: c = b;
      4'hC: c = ~(a | b);
      4'hD: begin c = b; for (int i = 0; i < sh; i++) c = {c[30:0], 1'b0}; end
      4'hE: begin c = b; for (int i = 0; i < sh; i++) c = {1'b0, c[31:1]}; end
      default: c = '0;
    endcase
    return {ov, c};
  endfunction

  function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          p, q, r;
    longint unsigned pu;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      default: begin
        if (b == 32'd0) begin
          lo = '1; hi = a;
        end else if (op == 3'd3) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) - q * longint'($signed(b));
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic alu_vec(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] e;
    A = a; B = b; Op = op;
    alu_sb.push_back(alu_ref(a, b, op));
    #1;
    e = alu_sb.pop_front();
    check($sformatf("alu_c op=%0h a=%0h b=%0h", op, a, b), 64'(C), 64'(e[31:0]));
    check($sformatf("alu_over op=%0h", op), 64'(Over), 64'(e[32]));
  endtask

  // Launch a mul/div at the next edge, track Busy, optionally poke an mthi mid-run or hold Start.
  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke, input bit hold);
    md_exp_t e;
    int      n;
    e.tag = tag;
    e.lat = (op <= 3'd2) ? 5 : 10;
    md_ref(op, a, b, e.hi, e.lo);
    md_sb.push_back(e);
    MdOp = op; A = a; B = b; Start = 1'b1;
    @(posedge clk); #1;
    if (!hold) Start = 1'b0;
    n = 0;
    while (Busy && n < 64) begin
      n++;
      check({tag, " hold_hi"}, 64'(HI), 64'(mhi));
      check({tag, " hold_lo"}, 64'(LO), 64'(mlo));
      if (!hold) alu_vec($urandom, $urandom, 4'($urandom));
      if (n == poke) begin
        Start = 1'b1; MdOp = 3'd5; A = 32'h1234;
      end else if (!hold) begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
    end
    e = md_sb.pop_front();
    check({e.tag, " busy_cycles"}, 64'(n), 64'(e.lat));
    check({e.tag, " hi"}, 64'(HI), 64'(e.hi));
    check({e.tag, " lo"}, 64'(LO), 64'(e.lo));
    mhi = e.hi;
    mlo = e.lo;
  endtask

  task automatic md_move(input string tag, input logic [2:0] op, input logic [31:0] a);
    MdOp = op; A = a; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    if (op == 3'd5) mhi = a;
    if (op == 3'd6) mlo = a;
    check({tag, " busy"}, 64'(Busy), 64'(0));
    check({tag, " hi"}, 64'(HI), 64'(mhi));
    check({tag, " lo"}, 64'(LO), 64'(mlo));
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MdOp = 3'd0; A = '0; B = '0; Op = '0;
    a16 = '0; b16 = '0; op16 = '0; md16 = '0; st16 = 1'b0;
    mhi = '0; mlo = '0;
    #2;
    check("reset busy", 64'(Busy), 64'(0));
    check("reset hi", 64'(HI), 64'(0));
    check("reset lo", 64'(LO), 64'(0));
    alu_vec(32'h7FFFFFFF, 32'h1, 4'h2);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU directed corners and a random sweep
    alu_vec(32'h7FFFFFFF, 32'h1, 4'h2);
    alu_vec(32'h4, 32'h80000000, 4'h9);
    alu_vec(32'h1, 32'hFFFFFFFF, 4'h8);
    alu_vec(32'h1, 32'hFFFFFFFF, 4'h7);
    alu_vec(32'h80000000, 32'h1, 4'h6);
    alu_vec(32'hFFFFFFE4, 32'h80000001, 4'hD);
    alu_vec(32'h3F, 32'h80000000, 4'hE);
    alu_vec(32'h12, 32'h34, 4'hF);
    for (int i = 0; i < 60; i++) alu_vec($urandom, $urandom, 4'($urandom));

    // multiply / divide results and latency
    md_run("mult",      3'd1, 32'hFFFFFFFF, 32'd2, -1, 1'b0);
    md_run("multu",     3'd2, 32'hFFFFFFFF, 32'd2, -1, 1'b0);
    md_run("div",       3'd3, -32'sd7, 32'd2, -1, 1'b0);
    md_run("divu_by0",  3'd4, 32'd7, 32'd0, -1, 1'b0);
    md_run("div_by0",   3'd3, 32'hFFFFFFF9, 32'd0, -1, 1'b0);
    md_run("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    md_run("div_negb",  3'd3, 32'd7, -32'sd2, -1, 1'b0);
    md_run("divu",      3'd4, 32'd100, 32'd7, -1, 1'b0);
    for (int i = 0; i < 4; i++)
      md_run($sformatf("rand%0d", i), 3'(1 + (i % 4)), $urandom, $urandom_range(1, 70000), -1, 1'b0);

    // mthi while busy is ignored
    md_run("collide", 3'd3, -32'sd7, 32'd2, 3, 1'b0);
    Start = 1'b0;

    // direct moves and reserved codes
    md_move("mthi", 3'd5, 32'hCAFE0001);
    md_move("mtlo", 3'd6, 32'hBEEF0002);
    md_move("rsvd0", 3'd0, 32'h11111111);
    md_move("rsvd7", 3'd7, 32'h22222222);

    // held Start relaunches right after completion
    md_run("held1", 3'd2, 32'h10001, 32'h30003, -1, 1'b1);
    md_run("held2", 3'd2, 32'h10001, 32'h30003, -1, 1'b0);

    // reset in the middle of a multiply
    MdOp = 3'd1; A = 32'h55; B = 32'h77; Start = 1'b1;
    @(posedge clk); #1; Start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst busy", 64'(Busy), 64'(0));
    check("midrst hi", 64'(HI), 64'(0));
    check("midrst lo", 64'(LO), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("postrst busy", 64'(Busy), 64'(0));
    check("postrst hi", 64'(HI), 64'(0));
    check("postrst lo", 64'(LO), 64'(0));
    mhi = '0; mlo = '0;

    // 16-bit instance: one-cycle multiply and 4-bit shift amount
    a16 = 16'h8000; b16 = 16'h8000; md16 = 3'd1; st16 = 1'b1;
    @(posedge clk); #1; st16 = 1'b0;
    check("w16 busy", 64'(busy16), 64'(1));
    @(posedge clk); #1;
    check("w16 busy_end", 64'(busy16), 64'(0));
    check("w16 hi", 64'(hi16), 64'(16'h4000));
    check("w16 lo", 64'(lo16), 64'(16'h0000));
    a16 = 16'h0013; b16 = 16'h8000; op16 = 4'h9; #1;
    check("w16 sra", 64'(c16), 64'(16'hF000));
    op16 = 4'hE; #1;
    check("w16 srl", 64'(c16), 64'(16'h1000));
    b16 = 16'h0001; op16 = 4'hD; #1;
    check("w16 sll", 64'(c16), 64'(16'h0008));
    a16 = 16'h7FFF; b16 = 16'h0001; op16 = 4'h2; #1;
    check("w16 add_over", 64'({over16, c16}), 64'({1'b1, 16'h8000}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter MUL_LAT, default 5, multiply latency in cycles; SHALL be at least 1.
REQ-003 Parameter DIV_LAT, default 10, divide latency in cycles; SHALL be at least 1.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 A  input  WIDTH  operand A, which also supplies the shift amount.
REQ-007 B  input  WIDTH  operand B, which is also the shifted value.
REQ-008 Op  input  4  combinational ALU operation select.
REQ-009 C  output  WIDTH  combinational ALU result.
REQ-010 Over  output  1  signed overflow flag for add and subtract.
REQ-011 MdOp  input  3  multiply/divide operation select: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; values 0 and 7 are reserved.
REQ-012 Start  input  1  single-cycle launch strobe for MdOp.
REQ-013 Busy  output  1  high while a multiply or divide is in progress.
REQ-014 HI  output  WIDTH  HI register: upper product half or remainder.
REQ-015 LO  output  WIDTH  LO register: lower product half or quotient.

Function
REQ-016 C SHALL be combinational from A, B and Op, with no added latency, using these encodings: 0000 A&B; 0001 A|B; 0010 A+B; 0011 A^B; 0110 A-B; 0111 signed A<B gives 1, else 0; 1000 unsigned A<B gives 1, else 0; 1001 B arithmetic right shift by sh; 1010 B; 1100 ~(A|B); 1101 B<<sh; 1110 B logical right shift by sh; any other code gives 0.
REQ-017 sh SHALL be A[log2(WIDTH)-1:0]; the upper bits of A SHALL be ignored for shifts.
REQ-018 Add and subtract SHALL wrap modulo 2^WIDTH.
REQ-019 For Op 0010 and 0110, Over SHALL be 1 exactly when the signed result overflows; for every other Op, Over SHALL be 0.
REQ-020 The multiply/divide unit SHALL have two states, IDLE and RUN, plus a down-counter of log2(max(MUL_LAT,DIV_LAT))+1 bits.
REQ-021 In IDLE with Start=1 and MdOp in 1..4, the unit SHALL latch A, B and MdOp at the edge, move to RUN, and load the counter with MUL_LAT (1,2) or DIV_LAT (3,4).
REQ-022 In RUN, Busy SHALL be 1 and the counter SHALL decrement once per cycle.
REQ-023 At the edge where the counter reaches 0, HI/LO SHALL load the result and the unit SHALL return to IDLE with Busy=0.
REQ-024 A Start sampled at edge k SHALL produce Busy=1 for exactly LAT cycles, and the new HI/LO SHALL be visible after edge k+LAT.
REQ-025 HI/LO SHALL hold their previous values throughout RUN; operand changes after launch SHALL have no effect on the result.
REQ-026 mult/multu SHALL produce the full 2*WIDTH product, signed or unsigned, with HI as the upper half and LO as the lower half.
REQ-027 div/divu SHALL set LO to the quotient and HI to the remainder; signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-028 Divide by zero (B=0) SHALL give LO = all ones and HI = A, for both div and divu.
REQ-029 Signed overflow (A = -2^(WIDTH-1), B = -1, div) SHALL give LO = -2^(WIDTH-1) and HI = 0.
REQ-030 In IDLE with Start=1, MdOp=5 SHALL load HI with A at the edge and MdOp=6 SHALL load LO with A at the edge; Busy SHALL remain 0 for both.
REQ-031 Start while Busy=1 SHALL be ignored for every MdOp, including mthi and mtlo.
REQ-032 Start with MdOp 0 or 7 SHALL be ignored.
REQ-033 Start held high for multiple cycles SHALL launch only in cycles where the unit is IDLE; a held Start SHALL relaunch on the cycle after completion.
REQ-034 The combinational ALU path SHALL remain fully usable while Busy=1.

Reset
REQ-035 While reset=1, asynchronously: state SHALL be IDLE, the counter SHALL be 0, Busy SHALL be 0, and HI and LO SHALL be 0.
REQ-036 Reset asserted during RUN SHALL discard the operation; no HI/LO update SHALL follow the release of reset.
REQ-037 C and Over SHALL be unaffected by reset because they are purely combinational.

Verification
REQ-038 ALU sweep: A=0x7FFFFFFF, B=1, Op=0010 -> C=0x80000000, Over=1; Op=1001 with A=4, B=0x80000000 -> C=0xF8000000; Op=1000 with A=1, B=0xFFFFFFFF -> C=1.
REQ-039 mult: A=0xFFFFFFFF, B=2, Start at edge k -> Busy=1 for 5 cycles; after edge k+5, HI=0xFFFFFFFF and LO=0xFFFFFFFE; multu with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-040 div: A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu with A=7, B=0 -> LO=0xFFFFFFFF, HI=7; div with A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-041 Collision: start div, then pulse Start with MdOp=5 and A=0x1234 at cycle 3 -> the mthi is ignored, and HI holds the div remainder at completion.
REQ-042 Reset mid-op: start mult, assert reset at cycle 2 for one cycle -> Busy=0, HI=LO=0 immediately, and they stay 0 after the original completion time.
REQ-043 Parameter check: WIDTH=16, MUL_LAT=1 -> A=0x8000, B=0x8000 mult gives HI=0x4000, LO=0 after one cycle; shifts use A[3:0].
